reg_write_arbiter: RTL

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter_if.sv | 29 ++
 rtl/reg_write_arbiter.sv | 73 +++++++
 2 files changed

// File: rtl/reg_write_arbiter_if.sv
// rtl/reg_write_arbiter_if.sv - request, query and register-file port bundle for reg_write_arbiter
interface reg_write_arbiter_if;
  logic       HOLD;
  logic       A_VALID;
  logic [2:0] A_ADDR;
  logic [7:0] A_DATA;
  logic       A_READY;
  logic       B_VALID;
  logic [2:0] B_ADDR;
  logic [7:0] B_DATA;
  logic       B_READY;
  logic [2:0] RD1_ADDR;
  logic [2:0] RD2_ADDR;
  logic       HAZARD;
  logic       RF_WRITE;
  logic [2:0] RF_INADDRESS;
  logic [7:0] RF_IN;
  logic [7:0] BUSY;

  modport master (
    output HOLD, A_VALID, A_ADDR, A_DATA, B_VALID, B_ADDR, B_DATA, RD1_ADDR, RD2_ADDR,
    input  A_READY, B_READY, HAZARD, RF_WRITE, RF_INADDRESS, RF_IN, BUSY
  );

  modport slave (
    input  HOLD, A_VALID, A_ADDR, A_DATA, B_VALID, B_ADDR, B_DATA, RD1_ADDR, RD2_ADDR,
    output A_READY, B_READY, HAZARD, RF_WRITE, RF_INADDRESS, RF_IN, BUSY
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - two-requester register-file write arbiter with one-entry output stage
// and per-register outstanding-write scoreboard for hazard queries.
module reg_write_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  reg_write_arbiter_if.slave bus
);

  typedef enum logic {EMPTY, FULL} stage_t;

  stage_t     state;
  logic       last_b;
  logic [2:0] rf_addr;
  logic [7:0] rf_data;
  logic [7:0] busy;

  logic       open;
  logic       a_wins;
  logic       grant_a;
  logic       grant_b;
  logic       hs;
  logic [2:0] hs_addr;
  logic [7:0] hs_data;
  logic [7:0] busy_next;

  always_comb begin
    open    = !bus.HOLD && !RESET;
    a_wins  = !bus.B_VALID || FIXED_PRIO || last_b;
    grant_a = open && bus.A_VALID && a_wins;
    grant_b = open && bus.B_VALID && !(bus.A_VALID && a_wins);
    hs      = grant_a || grant_b;
    hs_addr = grant_b ? bus.B_ADDR : bus.A_ADDR;
    hs_data = grant_b ? bus.B_DATA : bus.A_DATA;

    // Retire clears first so a same-address accept at the same edge keeps the bit set.
    busy_next = busy;
    if (state == FULL) busy_next[rf_addr] = 1'b0;
    if (hs)            busy_next[hs_addr] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= EMPTY;
      rf_addr <= 3'd0;
      rf_data <= 8'd0;
      busy    <= 8'h00;
      last_b  <= 1'b1;
    end else begin
      busy <= busy_next;
      if (hs) begin
        state   <= FULL;
        rf_addr <= hs_addr;
        rf_data <= hs_data;
        last_b  <= grant_b;
      end else begin
        state <= EMPTY;
      end
    end
  end

  assign bus.A_READY      = grant_a;
  assign bus.B_READY      = grant_b;
  // A write still staged when reset arrives must never reach the register file.
  assign bus.RF_WRITE     = (state == FULL) && !RESET;
  assign bus.RF_INADDRESS = rf_addr;
  assign bus.RF_IN        = rf_data;
  assign bus.BUSY         = busy;
  assign bus.HAZARD       = busy[bus.RD1_ADDR] || busy[bus.RD2_ADDR] ||
                            (hs && (hs_addr == bus.RD1_ADDR || hs_addr == bus.RD2_ADDR));

endmodule
